// File: rtl/dca_row_merge_queue.sv
// Merges masked beats into a row accumulator and queues each closed row
// (row, byte strobe, info) in a small FIFO with registered head storage.
module dca_row_merge_queue #(
   parameter int BW_ROW     = 256,
   parameter int BW_INFO    = 16,
   parameter int DEPTH      = 4,
   parameter int DROP_EMPTY = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic                         enable,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [BW_ROW-1:0]            in_row,
   input  logic [BW_ROW-1:0]            in_bitmask,
   input  logic                         in_last,
   input  logic                         in_drop,
   input  logic [BW_INFO-1:0]           in_info,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [BW_ROW-1:0]            out_row,
   output logic [BW_ROW/8-1:0]          out_wstrb,
   output logic [BW_INFO-1:0]           out_info,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         pending
);
   localparam int NB = BW_ROW/8;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [BW_ROW-1:0]  acc_row_q, acc_row_d;
   logic [NB-1:0]      acc_wstrb_q, acc_wstrb_d;
   logic               pending_q, pending_d;
   logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]      count_q, count_d;
   logic [BW_ROW-1:0]  mem_row_q   [DEPTH];
   logic [NB-1:0]      mem_wstrb_q [DEPTH];
   logic [BW_INFO-1:0] mem_info_q  [DEPTH];

   logic [NB-1:0]      beat_strb, merged_strb;
   logic [BW_ROW-1:0]  merged_row;
   logic               accept, pop, push;

   // Byte strobe follows the lowest mask bit of each byte.
   always_comb begin
      beat_strb = '0;
      for (int i = 0; i < NB; i++) beat_strb[i] = in_bitmask[8*i];
   end

   assign in_ready    = enable & (count_q != CW'(DEPTH));
   assign out_valid   = (count_q != '0);
   assign accept      = in_valid & in_ready;
   assign pop         = out_valid & out_ready;
   assign merged_row  = (~in_bitmask & acc_row_q) | (in_bitmask & in_row);
   assign merged_strb = acc_wstrb_q | beat_strb;
   assign push        = accept & in_last & ~in_drop &
                        ~((DROP_EMPTY != 0) && (merged_strb == '0));

   always_comb begin
      acc_row_d   = acc_row_q;
      acc_wstrb_d = acc_wstrb_q;
      pending_d   = pending_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      if (clear) begin
         acc_row_d   = '0;
         acc_wstrb_d = '0;
         pending_d   = 1'b0;
         head_d      = '0;
         tail_d      = '0;
         count_d     = '0;
      end else begin
         // acc_row survives a row close; only the strobe restarts.
         if (accept) begin
            acc_row_d   = merged_row;
            acc_wstrb_d = in_last ? '0 : merged_strb;
            pending_d   = ~in_last;
         end
         if (push) tail_d = tail_q + PW'(1);
         if (pop)  head_d = head_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_row_q   <= '0;
         acc_wstrb_q <= '0;
         pending_q   <= 1'b0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_row_q[i]   <= '0;
            mem_wstrb_q[i] <= '0;
            mem_info_q[i]  <= '0;
         end
      end else begin
         acc_row_q   <= acc_row_d;
         acc_wstrb_q <= acc_wstrb_d;
         pending_q   <= pending_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         if (push && !clear) begin
            mem_row_q[tail_q]   <= merged_row;
            mem_wstrb_q[tail_q] <= merged_strb;
            mem_info_q[tail_q]  <= in_info;
         end
      end
   end

   assign out_row   = mem_row_q[head_q];
   assign out_wstrb = mem_wstrb_q[head_q];
   assign out_info  = mem_info_q[head_q];
   assign count     = count_q;
   assign pending   = pending_q;
endmodule

// File: tb/tb_dca_row_merge_queue.sv
// Randomized and directed bench for dca_row_merge_queue against a queue-based
// row-merge reference model.
module tb_dca_row_merge_queue;
   typedef struct packed {
      logic [31:0] row;
      logic [3:0]  strb;
      logic [15:0] info;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst, clear, enable, in_valid, in_valid2, in_last, in_drop, out_ready;
   logic [31:0] in_row, in_bitmask;
   logic [15:0] in_info;
   logic        in_ready, out_valid, pending;
   logic [31:0] out_row;
   logic [3:0]  out_wstrb;
   logic [15:0] out_info;
   logic [2:0]  count;
   logic        in_ready2, out_valid2, pending2;
   logic [31:0] out_row2;
   logic [3:0]  out_wstrb2;
   logic [15:0] out_info2;
   logic [2:0]  count2;

   int total = 0;
   int bad   = 0;

   ent_t        q[$];
   logic [31:0] macc;
   logic [3:0]  mstrb;
   bit          mpend;
   bit          rand_ordy = 0;

   always #5 clk = ~clk;

   dca_row_merge_queue #(.BW_ROW(32), .BW_INFO(16), .DEPTH(4), .DROP_EMPTY(1)) dut (
      .clk(clk), .rst(rst), .clear(clear), .enable(enable),
      .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row), .in_bitmask(in_bitmask),
      .in_last(in_last), .in_drop(in_drop), .in_info(in_info),
      .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
      .out_wstrb(out_wstrb), .out_info(out_info), .count(count), .pending(pending));

   dca_row_merge_queue #(.BW_ROW(32), .BW_INFO(16), .DEPTH(4), .DROP_EMPTY(0)) dut2 (
      .clk(clk), .rst(rst), .clear(clear), .enable(enable),
      .in_valid(in_valid2), .in_ready(in_ready2), .in_row(in_row), .in_bitmask(in_bitmask),
      .in_last(in_last), .in_drop(in_drop), .in_info(in_info),
      .out_valid(out_valid2), .out_ready(out_ready), .out_row(out_row2),
      .out_wstrb(out_wstrb2), .out_info(out_info2), .count(count2), .pending(pending2));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [3:0] strb_of(input logic [31:0] m);
      return {m[24], m[16], m[8], m[0]};
   endfunction

   function automatic bit m_rdy();
      return enable && (q.size() != 4);
   endfunction

   task automatic mreset();
      q.delete();
      macc  = '0;
      mstrb = '0;
      mpend = 0;
   endtask

   // One clock: compare at negedge, then advance the model at the edge.
   task automatic cyc(output bit acc);
      bit          pp;
      logic [31:0] r;
      logic [3:0]  s;
      if (rand_ordy) begin
         out_ready = 1'($urandom_range(0, 1));
         enable    = ($urandom_range(0, 7) != 0);
      end
      @(negedge clk);
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("count", 64'(count), 64'(q.size()));
      chk("in_ready", 64'(in_ready), 64'(m_rdy()));
      chk("pending", 64'(pending), 64'(mpend));
      if (q.size() != 0) begin
         chk("out_row", 64'(out_row), 64'(q[0].row));
         chk("out_wstrb", 64'(out_wstrb), 64'(q[0].strb));
         chk("out_info", 64'(out_info), 64'(q[0].info));
      end
      acc = in_valid && m_rdy();
      pp  = (q.size() != 0) && out_ready;
      @(posedge clk);
      if (rst || clear) mreset();
      else begin
         if (pp) void'(q.pop_front());
         if (acc) begin
            r = (~in_bitmask & macc) | (in_bitmask & in_row);
            s = mstrb | strb_of(in_bitmask);
            macc = r;
            if (in_last) begin
               if (!in_drop && s != 4'd0) q.push_back('{row: r, strb: s, info: in_info});
               mstrb = '0;
               mpend = 0;
            end else begin
               mstrb = s;
               mpend = 1;
            end
         end
      end
      #1;
   endtask

   task automatic beat(input logic [31:0] r, input logic [31:0] m, input bit l, input bit d,
                       input logic [15:0] inf);
      bit a;
      int n;
      n = 0;
      in_row = r; in_bitmask = m; in_last = l; in_drop = d; in_info = inf; in_valid = 1'b1;
      do begin
         cyc(a);
         n++;
      end while (!a && n < 200);
      if (!a) chk("beat_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) cyc(a);
   endtask

   initial begin
      bit a;
      logic [31:0] r1, r2;
      rst = 1'b1; clear = 1'b0; enable = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0;
      in_last = 1'b0; in_drop = 1'b0; out_ready = 1'b0;
      in_row = '0; in_bitmask = '0; in_info = '0;
      mreset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_pending", 64'(pending), 64'd0);
      chk("rst_row", 64'(out_row), 64'd0);
      chk("rst_wstrb", 64'(out_wstrb), 64'd0);
      chk("rst_info", 64'(out_info), 64'd0);
      rst = 1'b0;

      // merge of two partial beats
      beat(32'hAAAAAAAA, 32'h000000FF, 0, 0, 16'h0);
      beat(32'h55555555, 32'hFF000000, 1, 0, 16'h3);
      chk("merge_valid", 64'(out_valid), 64'd1);
      chk("merge_row", 64'(out_row), 64'h550000AA);
      chk("merge_wstrb", 64'(out_wstrb), 64'h9);
      chk("merge_info", 64'(out_info), 64'h3);
      out_ready = 1'b1; idle(1); out_ready = 1'b0;

      // dropped row and all-zero strobe row
      beat($urandom, 32'hFFFFFFFF, 1, 1, 16'h1);
      chk("drop_count", 64'(count), 64'd0);
      chk("drop_pending", 64'(pending), 64'd0);
      in_valid2 = 1'b1;
      beat($urandom, 32'h0, 1, 0, 16'h5);
      in_valid2 = 1'b0;
      chk("empty_count", 64'(count), 64'd0);
      chk("empty_count_de0", 64'(count2), 64'd1);
      chk("empty_wstrb_de0", 64'(out_wstrb2), 64'd0);
      chk("empty_info_de0", 64'(out_info2), 64'h5);

      // fill, hold a fifth beat, then release with one pop
      for (int i = 0; i < 4; i++) beat($urandom, $urandom, 1, 0, 16'(i + 16'h10));
      chk("full_count", 64'(count), 64'd4);
      chk("full_ready", 64'(in_ready), 64'd0);
      in_row = $urandom; in_bitmask = 32'hFFFFFFFF; in_last = 1'b1; in_drop = 1'b0;
      in_info = 16'h20; in_valid = 1'b1;
      idle(2);
      chk("held_count", 64'(count), 64'd4);
      out_ready = 1'b1; idle(1); out_ready = 1'b0;
      chk("pop_ready", 64'(in_ready), 64'd1);
      idle(1);
      chk("refill_count", 64'(count), 64'd4);
      in_valid = 1'b0;
      out_ready = 1'b1; idle(6); out_ready = 1'b0;

      // simultaneous push and pop at count 2
      r1 = $urandom; r2 = $urandom;
      beat(r1, 32'hFFFFFFFF, 1, 0, 16'h31);
      beat(r2, 32'hFFFFFFFF, 1, 0, 16'h32);
      chk("sim_head0", 64'(out_row), 64'(r1));
      out_ready = 1'b1;
      beat($urandom, 32'hFFFFFFFF, 1, 0, 16'h33);
      out_ready = 1'b0;
      chk("sim_count", 64'(count), 64'd2);
      chk("sim_head1", 64'(out_row), 64'(r2));
      out_ready = 1'b1; idle(3); out_ready = 1'b0;

      // clear with three queued rows and an open row
      for (int i = 0; i < 3; i++) beat($urandom, 32'hFFFFFFFF, 1, 0, 16'(i));
      beat($urandom, $urandom | 32'h1, 0, 0, 16'h0);
      chk("preclr_pending", 64'(pending), 64'd1);
      chk("preclr_count", 64'(count), 64'd3);
      clear = 1'b1; in_valid = 1'b1; in_last = 1'b1; out_ready = 1'b1;
      idle(1);
      clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      chk("clr_count", 64'(count), 64'd0);
      chk("clr_pending", 64'(pending), 64'd0);
      chk("clr_valid", 64'(out_valid), 64'd0);

      // reset mid-row, next row merges from a zeroed accumulator
      beat(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 16'h0);
      rst = 1'b1; idle(1); rst = 1'b0;
      chk("rstmid_pending", 64'(pending), 64'd0);
      chk("rstmid_count", 64'(count), 64'd0);
      chk("rstmid_row", 64'(out_row), 64'd0);
      beat(32'h12345678, 32'h000000FF, 1, 0, 16'h7);
      chk("rstmid_merge_row", 64'(out_row), 64'h00000078);
      chk("rstmid_merge_wstrb", 64'(out_wstrb), 64'h1);
      out_ready = 1'b1; idle(2); out_ready = 1'b0;

      // random backpressure over 100 rows
      rand_ordy = 1;
      for (int rw = 0; rw < 100; rw++) begin
         int nb;
         nb = $urandom_range(1, 3);
         for (int b = 0; b < nb; b++) begin
            idle($urandom_range(0, 2));
            beat($urandom, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom, (b == nb - 1),
                 ($urandom_range(0, 15) == 0), 16'($urandom));
         end
      end
      rand_ordy = 0;
      enable = 1'b1; out_ready = 1'b1;
      idle(8);
      chk("drain_count", 64'(count), 64'd0);
      chk("drain_valid", 64'(out_valid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dca_row_merge_queue.md
DCA_ROW_MERGE_QUEUE -- requirements
Module: dca_row_merge_queue

Interface
REQ-001 SHALL have parameter BW_ROW, default 256, meaning merged row width in bits (multiple of 8, >=8).
REQ-002 SHALL have parameter BW_INFO, default 16, meaning opaque per-row transaction info width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning output queue entries (power of 2, >=2).
REQ-004 SHALL have parameter DROP_EMPTY, default 1, meaning a closed row with all-zero strobe is discarded when 1.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-006 SHALL have port clear, input, 1: synchronous flush of accumulator and queue.
REQ-007 SHALL have port enable, input, 1: gates input acceptance.
REQ-008 SHALL have ports in_valid, input, 1, and in_ready, output, 1: input handshake.
REQ-009 SHALL have port in_row, input, BW_ROW: beat data.
REQ-010 SHALL have port in_bitmask, input, BW_ROW: per-bit write mask.
REQ-011 SHALL have port in_last, input, 1: closes the row.
REQ-012 SHALL have port in_drop, input, 1: discards the row on close.
REQ-013 SHALL have port in_info, input, BW_INFO: info for the row.
REQ-014 SHALL have ports out_valid, output, 1, and out_ready, input, 1: output handshake.
REQ-015 SHALL have ports out_row, output, BW_ROW; out_wstrb, output, BW_ROW/8; and out_info, output, BW_INFO: head entry.
REQ-016 SHALL have port count, output, clog2(DEPTH+1): occupied queue entries.
REQ-017 SHALL have port pending, output, 1: accumulator holds at least one accepted beat of an open row.

Function
REQ-018 SHALL define accept = in_valid & in_ready and pop = out_valid & out_ready.
REQ-019 SHALL drive in_ready = enable & (count != DEPTH), with no combinational path from out_ready.
REQ-020 SHALL derive beat strobe byte i from in_bitmask[8*i].
REQ-021 SHALL on accept set acc_row <= (~in_bitmask & acc_row) | (in_bitmask & in_row) and acc_wstrb <= acc_wstrb | beat strobe.
REQ-022 SHALL on accept with in_last compute the merged row/strobe including the current beat and push {merged row, merged strobe, in_info} to the queue tail, unless in_drop=1 or (DROP_EMPTY=1 and merged strobe==0).
REQ-023 SHALL on accept with in_last, whether pushed or not, clear acc_wstrb and pending; acc_row is retained.
REQ-024 SHALL on accept without in_last set pending=1; in_drop is ignored unless in_last=1.
REQ-025 SHALL drive out_valid = (count != 0), with out_row, out_wstrb and out_info taken from registered head storage.
REQ-026 SHALL advance head and decrement count on pop.
REQ-027 SHALL have latency as follows: a closing beat accepted in cycle N into an empty queue gives out_valid=1 in cycle N+1.
REQ-028 SHALL on simultaneous push and pop leave count unchanged, with ordering strictly FIFO.
REQ-029 SHALL wrap head/tail pointers modulo DEPTH; overflow is unreachable through REQ-019.
REQ-030 SHALL when clear=1 empty the queue, zero acc_row and acc_wstrb, drop pending, and ignore same-cycle accept/pop.
REQ-031 SHALL hold out_* stable while out_valid=1 and out_ready=0.

Reset
REQ-032 SHALL have rst take priority over clear and all handshakes.
REQ-033 SHALL while rst=1 force count=0, out_valid=0, pending=0, out_row=0, out_wstrb=0, out_info=0, acc_row=0, acc_wstrb=0, and pointers=0.
REQ-034 SHALL when rst asserts mid-row or with a full queue discard all state with no partial output; in_ready follows REQ-019 from the next cycle.

Verification
REQ-035 SHALL be verified on the merge scenario: BW_ROW=32; beat1 row=0xAAAAAAAA, mask=0x000000FF; beat2 row=0x55555555, mask=0xFF000000, last, info=0x3 -> one entry with row=0x550000AA, wstrb=0b1001, info=0x3, out_valid at cycle after beat2.
REQ-036 SHALL be verified on the drop/empty scenario: a closing beat with in_drop=1 -> count stays 0, pending=0; a single closing beat with mask=0 and DROP_EMPTY=1 -> nothing pushed, and with DROP_EMPTY=0 -> entry with wstrb=0.
REQ-037 SHALL be verified on the full scenario: DEPTH=4, out_ready=0, 4 closing beats -> count=4, in_ready=0; a 5th beat is held; one pop -> in_ready=1 next cycle and data order is preserved.
REQ-038 SHALL be verified on the simultaneous scenario: count=2 with push and pop in the same cycle -> count=2 and the popped entry is the oldest.
REQ-039 SHALL be verified on the clear/reset scenario: clear=1 with count=3 and pending=1 -> next cycle count=0, pending=0, out_valid=0; rst asserted mid-row likewise, then a new row merges from zeroed acc_row.
REQ-040 SHALL be verified on the backpressure scenario: out_ready toggling randomly over 100 rows -> out_* stable while stalled, no loss or duplication against the scoreboard.
